// File: rtl/floating_point_op_sequencer_pkg.sv
// Shared constants for the floating-point operation sequencer: FSM encoding,
// default run length / timeout and the operand padding used to widen ROM bytes.
package floating_point_op_sequencer_pkg;

  localparam int unsigned DefaultNumOps  = 10;
  localparam int unsigned DefaultTimeout = 255;

  // ROM byte lands in the sign/exponent field; the mantissa tail is zero.
  localparam logic [23:0] OpPad = 24'h000000;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StFetch   = 3'd1;
  localparam logic [2:0] StRomWait = 3'd2;
  localparam logic [2:0] StIssue   = 3'd3;
  localparam logic [2:0] StWaitRes = 3'd4;
  localparam logic [2:0] StDone    = 3'd5;

  function automatic logic [31:0] pad_operand(input logic [7:0] rom_byte);
    return {rom_byte, OpPad};
  endfunction

endpackage

// File: rtl/floating_point_op_sequencer_if.sv
// Operand/result handshake between the sequencer (master) and the FP core (slave).
interface floating_point_op_sequencer_if;

  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_data;
  logic        res_valid;
  logic [31:0] res_data;

  modport master (
    output op_valid,
    output op_data,
    input  op_ready,
    input  res_valid,
    input  res_data
  );

  modport slave (
    input  op_valid,
    input  op_data,
    output op_ready,
    output res_valid,
    output res_data
  );

endinterface

// File: rtl/floating_point_op_sequencer_timer.sv
// Result-wait timer: counts enabled cycles since the last clear and flags when
// TIMEOUT waiting cycles have elapsed (the expiring cycle itself is not counted).
module fp_seq_timer
  import floating_point_op_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout,
  localparam int unsigned CntW   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == CntW'(TIMEOUT - 1));

  // Clear wins over enable; the count holds once expired.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/floating_point_op_sequencer.sv
// Walks NUM_OPS entries of an external operation ROM, issuing each byte as a
// padded single-precision operand to the FP core and waiting for its result
// before fetching the next one. Aborts with a sticky error on result timeout.
module floating_point_op_sequencer
  import floating_point_op_sequencer_pkg::*;
#(
  parameter int unsigned NUM_OPS = DefaultNumOps,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                timeout_err_o,
  output logic [3:0]                          rom_rd_addr_o,
  input  logic [7:0]                          rom_dout_i,
  floating_point_op_sequencer_if.master       core_if,
  output logic [31:0]                         last_result_o,
  output logic [4:0]                          res_cnt_o
);

  localparam logic [3:0] LastIdx = 4'(NUM_OPS - 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  addr_q, addr_d;
  logic [31:0] op_data_q, op_data_d;
  logic [31:0] last_q, last_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        terr_q, terr_d;
  logic        handshake;
  logic        tmr_clear, tmr_en, tmr_expired;

  assign handshake = (state_q == StIssue) && core_if.op_ready;

  fp_seq_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (tmr_clear),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  // Next-state logic. The ROM address is loaded on entry to FETCH so the
  // synchronous ROM samples it at the end of FETCH and its data is captured
  // at the end of ROM_WAIT.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    op_data_d = op_data_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    terr_d    = terr_q;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StFetch;
          idx_d     = 4'd0;
          addr_d    = 4'd0;
          cnt_d     = 5'd0;
          terr_d    = 1'b0;
          busy_d    = 1'b1;
          tmr_clear = 1'b1;
        end
      end
      StFetch: begin
        state_d = StRomWait;
      end
      StRomWait: begin
        op_data_d = pad_operand(rom_dout_i);
        state_d   = StIssue;
      end
      StIssue: begin
        if (handshake) begin
          state_d   = StWaitRes;
          tmr_clear = 1'b1;
        end
      end
      StWaitRes: begin
        if (core_if.res_valid) begin
          last_d = core_if.res_data;
          cnt_d  = cnt_q + 5'd1;
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 4'd1;
            addr_d  = idx_q + 4'd1;
            state_d = StFetch;
          end
        end else if (tmr_expired) begin
          terr_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          tmr_en = 1'b1;
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= 4'd0;
      addr_q    <= 4'd0;
      op_data_q <= 32'd0;
      last_q    <= 32'd0;
      cnt_q     <= 5'd0;
      busy_q    <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      op_data_q <= op_data_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      terr_q    <= terr_d;
    end
  end

  assign core_if.op_valid = (state_q == StIssue);
  assign core_if.op_data  = op_data_q;
  assign done_o           = (state_q == StDone);
  assign busy_o           = busy_q;
  assign timeout_err_o    = terr_q;
  assign rom_rd_addr_o    = addr_q;
  assign last_result_o    = last_q;
  assign res_cnt_o        = cnt_q;

endmodule

// File: tb/tb_floating_point_op_sequencer.sv
// Scoreboard bench: stimulus pushes expected operands, a monitor pops and
// compares on every presented operand; a small core model returns ~operand
// two cycles after each handshake.
module tb_floating_point_op_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic [3:0]  rom_rd_addr;
  logic [7:0]  rom_dout;
  logic [31:0] last_result;
  logic [4:0]  res_cnt;
  logic [7:0]  rom [16];

  floating_point_op_sequencer_if u_if ();

  floating_point_op_sequencer u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start),
    .busy_o        (busy),
    .done_o        (done),
    .timeout_err_o (timeout_err),
    .rom_rd_addr_o (rom_rd_addr),
    .rom_dout_i    (rom_dout),
    .core_if       (u_if),
    .last_result_o (last_result),
    .res_cnt_o     (res_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM, one cycle read latency.
  always_ff @(posedge clk) rom_dout <= rom[rom_rd_addr];

  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] exp_q [$];
  int          done_cnt = 0;
  int          hs_a3 = 0;
  int          stall_seen = 0;
  bit          outstanding = 0;
  bit          core_en = 1;
  bit          stall_arm = 0;
  bit          inject = 0;
  int          pend = 0;
  int          stall = 0;
  logic [31:0] pend_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_run(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = rom[i];
      exp_q.push_back({b, 24'h000000});
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (!busy) break;
    end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  // Core model: ready/stall control and delayed result return.
  initial begin
    u_if.op_ready  = 1'b1;
    u_if.res_valid = 1'b0;
    u_if.res_data  = '0;
    forever begin
      @(negedge clk);
      u_if.res_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          u_if.res_valid = 1'b1;
          u_if.res_data  = ~pend_data;
        end
      end else if (inject) begin
        inject         = 0;
        u_if.res_valid = 1'b1;
        u_if.res_data  = 32'hdeadbeef;
      end
      if (stall_arm && u_if.op_valid && u_if.op_data == 32'ha3000000) begin
        stall_arm = 0;
        stall     = 5;
      end
      if (stall > 0) begin
        u_if.op_ready = 1'b0;
        stall--;
      end else begin
        u_if.op_ready = 1'b1;
      end
      if (core_en && u_if.op_valid && u_if.op_ready) begin
        pend      = 2;
        pend_data = u_if.op_data;
      end
    end
  end

  // Monitor: scoreboard pop/compare on every presented operand.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (done) done_cnt++;
      if (!busy || u_if.res_valid) outstanding = 0;
      if (u_if.op_valid) begin
        chk("single_outstanding", {31'd0, outstanding}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_operand", u_if.op_data, 32'hxxxxxxxx);
        end else begin
          chk(u_if.op_ready ? "op_data" : "op_data_stall_hold", u_if.op_data, exp_q[0]);
          if (u_if.op_ready) begin
            void'(exp_q.pop_front());
            outstanding = 1;
            if (u_if.op_data == 32'ha3000000) hs_a3++;
          end else begin
            stall_seen++;
          end
        end
      end
    end
  end

  initial begin
    int k;
    logic [7:0] rom_init [10] = '{8'h48, 8'h65, 8'ha3, 8'h5c, 8'hf2,
                                  8'hdd, 8'h9b, 8'h62, 8'hd5, 8'h0f};
    for (int i = 0; i < 16; i++) rom[i] = (i < 10) ? rom_init[i] : 8'h00;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_terr", {31'd0, timeout_err}, 32'd0);
    chk("rst_addr", {28'd0, rom_rd_addr}, 32'd0);
    chk("rst_op_valid", {31'd0, u_if.op_valid}, 32'd0);
    chk("rst_op_data", u_if.op_data, 32'd0);
    chk("rst_last", last_result, 32'd0);
    chk("rst_cnt", {27'd0, res_cnt}, 32'd0);

    // Run 1: start on first edge after reset release, full sequence.
    push_run(10);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("first_edge_start_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    wait_idle("run1_finish");
    chk("run1_res_cnt", {27'd0, res_cnt}, 32'd10);
    chk("run1_last", last_result, 32'hf0ffffff);
    chk("run1_done_cnt", done_cnt, 1);
    chk("run1_queue_empty", exp_q.size(), 0);

    // res_valid while idle is ignored.
    @(negedge clk);
    inject = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_res_last", last_result, 32'hf0ffffff);
    chk("idle_res_cnt", {27'd0, res_cnt}, 32'd10);

    // Timeout: core never answers entry 0.
    core_en  = 0;
    done_cnt = 0;
    push_run(1);
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (u_if.op_valid && u_if.op_ready) break;
    end
    @(posedge clk);
    k = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (timeout_err) begin
        k = i;
        break;
      end
    end
    chk("timeout_latency", k, 255);
    chk("timeout_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("timeout_sticky", {31'd0, timeout_err}, 32'd1);
    chk("timeout_no_done", done_cnt, 0);
    core_en = 1;

    // Run 2: stall on entry 2, spurious start during entry 4.
    done_cnt   = 0;
    hs_a3      = 0;
    stall_seen = 0;
    stall_arm  = 1;
    push_run(10);
    pulse_start();
    #1;
    chk("restart_clears_terr", {31'd0, timeout_err}, 32'd0);
    chk("restart_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #1;
      if (busy && rom_rd_addr == 4'd4) break;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("run2_finish");
    chk("run2_res_cnt", {27'd0, res_cnt}, 32'd10);
    chk("run2_done_cnt", done_cnt, 1);
    chk("run2_stall_cycles", stall_seen, 5);
    chk("run2_a3_handshakes", hs_a3, 1);
    chk("run2_queue_empty", exp_q.size(), 0);

    // Run 3: reset while waiting for entry 6 result.
    done_cnt = 0;
    push_run(7);
    pulse_start();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #1;
      if (u_if.op_valid && u_if.op_ready && u_if.op_data == 32'h9b000000) break;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_op_valid", {31'd0, u_if.op_valid}, 32'd0);
    chk("midrst_op_data", u_if.op_data, 32'd0);
    chk("midrst_addr", {28'd0, rom_rd_addr}, 32'd0);
    chk("midrst_last", last_result, 32'd0);
    chk("midrst_cnt", {27'd0, res_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("late_res_cnt", {27'd0, res_cnt}, 32'd0);
    chk("late_res_last", last_result, 32'd0);
    chk("late_res_busy", {31'd0, busy}, 32'd0);
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/floating_point_op_sequencer.md
FLOATING_POINT_OP_SEQUENCER -- requirements
Module: floating_point_op_sequencer

Interface
REQ-001 Parameter NUM_OPS, default 10, number of operation ROM entries issued per run (1..16).
REQ-002 Parameter TIMEOUT, default 255, maximum cycles waited for a result before abort.
REQ-003 clk  input  1  sole clock; all logic rising-edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins a run when idle.
REQ-006 busy  output  1  high from accepted start until done/error.
REQ-007 done  output  1  one-cycle pulse when a run completes normally.
REQ-008 timeout_err  output  1  sticky; set on result timeout, cleared by next accepted start.
REQ-009 rom_rd_addr  output  4  read address to operation ROM.
REQ-010 rom_dout  input  8  ROM data, valid one cycle after rom_rd_addr is sampled.
REQ-011 op_valid  output  1  operand valid to floating-point core.
REQ-012 op_ready  input  1  core accepts operand when op_valid && op_ready.
REQ-013 op_data  output  32  single-precision operand.
REQ-014 res_valid  input  1  core result strobe, one cycle.
REQ-015 res_data  input  32  core result.
REQ-016 last_result  output  32  most recent captured result.
REQ-017 res_cnt  output  5  results captured in current run.

Function
REQ-018 FSM states: IDLE, FETCH, ROM_WAIT, ISSUE, WAIT_RES, DONE.
REQ-019 IDLE: start=1 -> FETCH; clear res_cnt, timeout_err; op index := 0; busy := 1 next cycle.
REQ-020 start while busy ignored; no restart, no effect on run.
REQ-021 FETCH: rom_rd_addr := op index; next ROM_WAIT (one ROM latency cycle).
REQ-022 ROM_WAIT: capture op_data := {rom_dout, 24'h000000}; next ISSUE.
REQ-023 ISSUE: op_valid=1, op_data stable until op_ready; on handshake op_valid deasserts next cycle, go WAIT_RES, clear timeout counter.
REQ-024 WAIT_RES: res_valid=1 -> last_result := res_data, res_cnt +1; if index = NUM_OPS-1 go DONE else index +1, go FETCH.
REQ-025 WAIT_RES: counter increments each cycle without res_valid; reaching TIMEOUT -> timeout_err := 1, busy := 0, go IDLE, no done pulse.
REQ-026 res_valid outside WAIT_RES ignored (no capture, no count).
REQ-027 DONE: done=1 for exactly one cycle, busy := 0, go IDLE.
REQ-028 Strictly one operand outstanding; next op_valid never before prior result.
REQ-029 Per-operation minimum latency: 3 cycles FETCH->ISSUE plus core latency.
REQ-030 Index never exceeds NUM_OPS-1; no wrap within a run.
REQ-031 rom_rd_addr holds last value outside FETCH.

Reset
REQ-032 rst_n low asynchronously forces IDLE; busy, done, op_valid, timeout_err = 0; rom_rd_addr, op_data, last_result, res_cnt, counters = 0.
REQ-033 Reset mid-run aborts immediately; no done pulse; outstanding core result after release ignored.
REQ-034 First start honoured on first clock edge after rst_n deasserted.

Structure
REQ-035 Shared package holds FSM state encoding, default NUM_OPS, default TIMEOUT, operand padding constant 24'h000000.
REQ-036 Timeout counter implemented as sub-module fp_seq_timer (clear, enable, expired output).
REQ-037 ROM is instantiated outside this block; no ROM contents inside it.

Verification
REQ-038 Reset then start with ROM contents 48,65,a3,5c,f2,dd,9b,62,d5,0f, op_ready=1, result 2 cycles after issue -> op_data sequence 32'h48000000..32'h0f000000, res_cnt=10, one done pulse.
REQ-039 op_ready held low 5 cycles on entry 2 -> op_valid and op_data=32'ha3000000 stable all 5 cycles, single handshake.
REQ-040 No res_valid after entry 0 issue, TIMEOUT=255 -> timeout_err=1 exactly 255 cycles after handshake, busy=0, done never asserted.
REQ-041 start pulsed during busy at entry 4 -> run unaffected, res_cnt ends 10, one done.
REQ-042 rst_n asserted in WAIT_RES of entry 6 -> all outputs zero asynchronously; late res_valid ignored, res_cnt stays 0.
REQ-043 res_valid pulsed in IDLE with res_data=32'hdeadbeef -> last_result unchanged, res_cnt unchanged.
